microseq_ctrl: RTL

MICROSEQ_CTRL -- requirements
Module: microseq_ctrl

---
 rtl/microseq_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/microseq_ctrl.sv
// Microprogrammed sequencer: a writable control store holding
// {ctl, seq, naddr} microwords, an opcode-to-entry-address map, and a
// three-state IDLE/RUN/HALT controller stepping the micro-PC.
module microseq_ctrl #(
  parameter int CTL_W  = 30,
  parameter int ADDR_W = 5,
  parameter int OPC_W  = 5,
  parameter int CS_W   = CTL_W + 2 + ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              zero_flag,
  input  logic [OPC_W-1:0]  opcode,
  input  logic              ucode_we,
  input  logic [ADDR_W-1:0] ucode_waddr,
  input  logic [CS_W-1:0]   ucode_wdata,
  input  logic              map_we,
  input  logic [OPC_W-1:0]  map_waddr,
  input  logic [ADDR_W-1:0] map_wdata,
  output logic [CTL_W-1:0]  cs,
  output logic [ADDR_W-1:0] upc,
  output logic              running,
  output logic              halted
);

  localparam int STORE_DEPTH = 2 ** ADDR_W;
  localparam int MAP_DEPTH   = 2 ** OPC_W;

  localparam logic [1:0] SEQ_NEXT = 2'b00;
  localparam logic [1:0] SEQ_MAP  = 2'b01;
  localparam logic [1:0] SEQ_BRNZ = 2'b10;
  localparam logic [1:0] SEQ_HALT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Control store and opcode map have no reset; their contents survive rst.
  logic [CS_W-1:0]   store_q [STORE_DEPTH];
  logic [ADDR_W-1:0] map_q   [MAP_DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] upc_q, upc_d;
  logic              running_q, halted_q;

  logic [CS_W-1:0]   uword;
  logic [CTL_W-1:0]  uword_ctl;
  logic [1:0]        uword_seq;
  logic [ADDR_W-1:0] uword_naddr;
  logic [ADDR_W-1:0] map_entry;
  logic [ADDR_W-1:0] upc_inc;

  // Asynchronous read of the current microword so cs tracks upc with no
  // latency; a write to the same entry shows up only after its edge.
  assign uword       = store_q[upc_q];
  assign uword_ctl   = uword[CS_W-1 -: CTL_W];
  assign uword_seq   = uword[ADDR_W +: 2];
  assign uword_naddr = uword[ADDR_W-1:0];
  assign map_entry   = map_q[opcode];
  assign upc_inc     = upc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

  // Table writes happen in every state, reset included.
  always_ff @(posedge clk) begin
    if (ucode_we) store_q[ucode_waddr] <= ucode_wdata;
    if (map_we)   map_q[map_waddr]     <= map_wdata;
  end

  // Next-state and next-micro-PC selection.
  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    unique case (state_q)
      RUN: begin
        if (!stall) begin
          unique case (uword_seq)
            SEQ_NEXT: upc_d = uword_naddr;
            SEQ_MAP:  upc_d = map_entry;
            SEQ_BRNZ: upc_d = zero_flag ? upc_inc : uword_naddr;
            SEQ_HALT: state_d = HALT;
            default:  upc_d = upc_q;
          endcase
        end
      end
      default: begin
        // IDLE and HALT: only start matters, stall is ignored.
        if (start) begin
          state_d = RUN;
          upc_d   = '0;
        end
      end
    endcase
  end

  // State register with registered status decodes; reset wins over all.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      upc_q     <= '0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      upc_q     <= upc_d;
      running_q <= (state_d == RUN);
      halted_q  <= (state_d == HALT);
    end
  end

  assign cs      = running_q ? uword_ctl : '0;
  assign upc     = upc_q;
  assign running = running_q;
  assign halted  = halted_q;

endmodule
